serial_load_sequencer: RTL and testbench
========================================

Name: serial_load_sequencer

Overview:
Sequencing controller for the serial datapoint loader. On `start` it fetches 16-bit feature words from a word memory and streams them bit-serially, LSB first, gap-free, onto the loader's `ser` input. The word order is datapoint-major and, within each datapoint, runs from the highest feature index down to 0. After the last bit it waits for the loader's `done`, then reports completion. It sits between the feature memory and the serial loader and owns all loader timing.

Parameters:
WORD_W, 16, bits per feature word; must be >= 2.
DP_W, 3, width of num_dp.
FEAT_W, 5, width of feat.
ADDR_W, 8, memory word-address width; must hold 2^DP_W * 2^FEAT_W - 1.
TIMEOUT, 64, cycles to wait for sink_done after the last bit.

Ports:
CLK  in  1  single clock; all logic is rising-edge.
RST  in  1  asynchronous, active-low reset.
start  in  1  begin a load; sampled only in IDLE.
num_dp  in  DP_W  number of datapoints to send (0..7).
feat  in  FEAT_W  highest feature index; each datapoint carries feat+1 words.
mem_re  out  1  memory read enable.
mem_addr  out  ADDR_W  memory word address.
mem_rdata  in  WORD_W  read data, valid the cycle after mem_re (1-cycle synchronous memory).
ser  out  1  serial bit to loader.
ser_valid  out  1  ser carries a stream bit.
sink_done  in  1  loader's done (level or pulse).
busy  out  1  high from start acceptance until done.
done  out  1  one-cycle completion pulse.
timeout  out  1  sticky; set if sink_done was missed; cleared on the next accepted start.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; mem_re, mem_addr, ser, ser_valid, busy, done and timeout are 0; all counters are 0.
- num_dp, feat and the inputs are latched when start is accepted. Later changes to them are ignored until the next IDLE.
- Address of the word for datapoint d, feature j = base_d + j, where base_d = d*(feat+1). base is accumulated by adding feat+1 per datapoint; no multiplier is used.
- Order: d=0..num_dp-1; for each d, j=feat down to 0.
- States: IDLE, FETCH, LOAD, SHIFT, WAIT_SINK, DONE.
- IDLE: start=1 and num_dp!=0 -> FETCH, busy=1. start=1 and num_dp=0 -> DONE; no mem_re is issued.
- FETCH (1 cycle): mem_re=1, mem_addr=feat (d=0, j=feat) -> LOAD.
- LOAD (1 cycle): mem_rdata is loaded into the shift register; bitcnt=0 -> SHIFT.
  - First ser_valid therefore appears 3 cycles after the start-sampling edge.
- SHIFT: ser=shift[0], ser_valid=1; the shift register shifts right each cycle; bitcnt increments.
  - Prefetch: at bitcnt==WORD_W-2, if words remain, mem_re=1 with the next address.
  - At bitcnt==WORD_W-1, if words remain, the shift register loads mem_rdata and bitcnt=0. The stream is gap-free.
  - If no words remain -> WAIT_SINK.
  - Total stream length is exactly num_dp*(feat+1)*WORD_W consecutive valid cycles.
- WAIT_SINK: ser_valid=0, ser=0; a wait counter runs.
  - sink_done=1 -> DONE.
  - Counter reaches TIMEOUT -> set timeout, -> DONE.
  - A sink_done already high on the entry cycle is accepted.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- start while busy is ignored. sink_done outside WAIT_SINK is ignored.
- mem_re is never asserted outside FETCH or the prefetch cycle; mem_addr holds its last value when mem_re=0.
- RST low mid-operation aborts immediately. A new start after reset release begins a fresh load from d=0.

Test Plan:
1. Memory word[a]=16'h1000+a; num_dp=5, feat=11; start pulse.
   -> 960 consecutive ser_valid bits carrying words at addresses 11..0, 23..12, ..., 59..48, each LSB first.
   -> Bench asserts sink_done 3 cycles after the last bit -> done pulses on the next cycle; timeout=0.
2. num_dp=1, feat=0, word[0]=16'hA5C3.
   -> First ser_valid 3 cycles after the start edge; bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; exactly 16 valid cycles; one mem_re at address 0.
3. num_dp=0, feat=7, start.
   -> No mem_re, no ser_valid; done pulses 1 cycle after the start edge.
4. num_dp=2, feat=3; start re-pulsed mid-stream and num_dp changed to 7 mid-stream.
   -> Stream unchanged: 128 bits from addresses 3..0, 7..4; single done pulse.
5. num_dp=1, feat=1; sink_done held 0.
   -> 32 bits; after TIMEOUT=64 cycles, done pulses with timeout=1.
   -> Next start clears timeout.
6. RST driven low at bit 5 of word 2.
   -> ser, ser_valid, mem_re and busy drop without waiting for a clock edge.
   -> After release, start with num_dp=1, feat=0 produces a correct 16-bit stream.

Source files
------------

// File: rtl/serial_load_sequencer.sv
// Fetches feature words from a 1-cycle synchronous memory and streams them LSB-first,
// gap-free, to the serial loader, then waits (with timeout) for the loader's done.
module serial_load_sequencer #(
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned DP_W    = 3,
  parameter int unsigned FEAT_W  = 5,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [DP_W-1:0]   num_dp,
  input  logic [FEAT_W-1:0] feat,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              ser,
  output logic              ser_valid,
  input  logic              sink_done,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int unsigned BitW  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(WORD_W - 1);
  localparam logic [BitW-1:0]  PreBit   = BitW'(WORD_W - 2);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StShift, StWaitSink, StDone} state_e;

  state_e            state_q, state_d;
  logic [DP_W-1:0]   num_dp_q, num_dp_d;
  logic [FEAT_W-1:0] feat_q, feat_d;
  logic [DP_W-1:0]   d_q, d_d;
  logic [FEAT_W-1:0] j_q, j_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [BitW-1:0]   bitcnt_q, bitcnt_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic [ADDR_W-1:0] addr_q;

  // Coordinates of the word following the one currently in the shift register.
  logic              more;
  logic [FEAT_W-1:0] nxt_j;
  logic [DP_W-1:0]   nxt_d;
  logic [ADDR_W-1:0] nxt_base, nxt_addr, step;

  always_comb begin
    step     = ADDR_W'(feat_q) + ADDR_W'(1);
    more     = (j_q != '0) || ((d_q + DP_W'(1)) != num_dp_q);
    nxt_j    = (j_q != '0) ? j_q - FEAT_W'(1) : feat_q;
    nxt_d    = (j_q != '0) ? d_q : d_q + DP_W'(1);
    nxt_base = (j_q != '0) ? base_q : base_q + step;
    nxt_addr = nxt_base + ADDR_W'(nxt_j);
  end

  always_comb begin
    state_d   = state_q;
    num_dp_d  = num_dp_q;
    feat_d    = feat_q;
    d_d       = d_q;
    j_d       = j_q;
    base_d    = base_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    mem_re    = 1'b0;
    mem_addr  = addr_q;
    ser       = 1'b0;
    ser_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          num_dp_d  = num_dp;
          feat_d    = feat;
          d_d       = '0;
          j_d       = feat;
          base_d    = '0;
          bitcnt_d  = '0;
          wait_d    = '0;
          timeout_d = 1'b0;
          state_d   = (num_dp != '0) ? StFetch : StDone;
        end
      end
      StFetch: begin
        busy     = 1'b1;
        mem_re   = 1'b1;
        mem_addr = ADDR_W'(feat_q);
        state_d  = StLoad;
      end
      StLoad: begin
        busy     = 1'b1;
        shift_d  = mem_rdata;
        bitcnt_d = '0;
        state_d  = StShift;
      end
      StShift: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        ser       = shift_q[0];
        // Prefetch lands exactly on the last-bit cycle, keeping the stream gap-free.
        if (bitcnt_q == PreBit && more) begin
          mem_re   = 1'b1;
          mem_addr = nxt_addr;
        end
        if (bitcnt_q == LastBit) begin
          if (more) begin
            shift_d  = mem_rdata;
            bitcnt_d = '0;
            d_d      = nxt_d;
            j_d      = nxt_j;
            base_d   = nxt_base;
          end else begin
            wait_d  = '0;
            state_d = StWaitSink;
          end
        end else begin
          shift_d  = shift_q >> 1;
          bitcnt_d = bitcnt_q + BitW'(1);
        end
      end
      StWaitSink: begin
        busy = 1'b1;
        if (sink_done) begin
          state_d = StDone;
        end else if (wait_q == WaitLast) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign timeout = timeout_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      num_dp_q  <= '0;
      feat_q    <= '0;
      d_q       <= '0;
      j_q       <= '0;
      base_q    <= '0;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      num_dp_q  <= num_dp_d;
      feat_q    <= feat_d;
      d_q       <= d_d;
      j_q       <= j_d;
      base_q    <= base_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      addr_q    <= mem_addr;
    end
  end

endmodule

// File: tb/tb_serial_load_sequencer.sv
// Directed bench for serial_load_sequencer: memory model, per-load trace capture and
// comparison against hand-derived streams, latencies and flags.
module tb_serial_load_sequencer;

  localparam int TO = 64;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  num_dp = '0;
  logic [4:0]  feat = '0;
  logic        mem_re;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata = '0;
  logic        ser, ser_valid;
  logic        sink_done = 1'b0;
  logic        busy, done, timeout;

  logic [15:0] mem [256];

  serial_load_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .num_dp    (num_dp),
    .feat      (feat),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .ser       (ser),
    .ser_valid (ser_valid),
    .sink_done (sink_done),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (mem_re) mem_rdata <= mem[mem_addr];

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Trace of the most recent load; sample index k is the cycle ending at the k-th edge
  // after the edge that sampled start.
  bit got_bits[$];
  int got_addrs[$];
  int first_valid, last_valid, n_valid, gaps, n_re, done_cnt, done_at;
  logic busy_at1, to_at1, to_at_done;

  task automatic run_load(input int ndp, input int ft, input int sink_lat, input bit poke);
    bit prev_v = 1'b0;
    bit fin = 1'b0;
    got_bits.delete();
    got_addrs.delete();
    first_valid = -1; last_valid = -1; n_valid = 0; gaps = 0; n_re = 0;
    done_cnt = 0; done_at = -1; to_at_done = 1'bx;
    @(negedge CLK);
    num_dp = ndp[2:0];
    feat   = ft[4:0];
    start  = 1'b1;
    for (int cyc = 1; cyc < 4000 && !fin; cyc++) begin
      @(negedge CLK);
      if (cyc == 1) begin
        busy_at1 = busy;
        to_at1   = timeout;
      end
      if (ser_valid) begin
        if (first_valid < 0) first_valid = cyc;
        else if (!prev_v) gaps++;
        got_bits.push_back(ser);
        last_valid = cyc;
        n_valid++;
      end
      prev_v = ser_valid;
      if (mem_re) begin
        n_re++;
        got_addrs.push_back(int'(mem_addr));
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at    = cyc;
          to_at_done = timeout;
        end
      end
      if (done_at >= 0 && cyc >= done_at + 3) fin = 1'b1;
      start     = 1'b0;
      sink_done = 1'b0;
      if (poke && cyc == 40) begin
        start  = 1'b1;
        num_dp = 3'd7;
      end
      if (sink_lat >= 0 && last_valid > 0 && !ser_valid && cyc == last_valid + sink_lat)
        sink_done = 1'b1;
    end
    sink_done = 1'b0;
  endtask

  task automatic check_stream(input string tag, input int ndp, input int ft);
    int idx = 0;
    int k = 0;
    int bad = 0;
    int abad = 0;
    int a;
    logic [15:0] w;
    for (int d = 0; d < ndp; d++) begin
      for (int j = ft; j >= 0; j--) begin
        a = d * (ft + 1) + j;
        w = mem[a];
        if (k >= got_addrs.size() || got_addrs[k] != a) abad++;
        k++;
        for (int b = 0; b < 16; b++) begin
          if (idx >= got_bits.size() || got_bits[idx] !== w[b]) bad++;
          idx++;
        end
      end
    end
    check_eq({tag, "_bits"}, bad, 0);
    check_eq({tag, "_len"}, n_valid, idx);
    check_eq({tag, "_gaps"}, gaps, 0);
    check_eq({tag, "_addrs"}, abad, 0);
    check_eq({tag, "_nre"}, n_re, k);
    check_eq({tag, "_first"}, first_valid, 3);
    check_eq({tag, "_ndone"}, done_cnt, 1);
  endtask

  function automatic logic [15:0] pack16();
    logic [15:0] pk = '0;
    for (int i = 0; i < 16 && i < got_bits.size(); i++) pk[i] = got_bits[i];
    return pk;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    logic pre_v;
    for (int a = 0; a < 256; a++) mem[a] = 16'h1000 + 16'(a);

    // Outputs during reset
    #3;
    check_eq("reset_outs", {26'd0, mem_re, ser, ser_valid, busy, done, timeout}, 32'd0);
    check_eq("reset_addr", mem_addr, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;

    // 1: five datapoints, twelve features, sink_done three cycles after the last bit
    run_load(5, 11, 3, 1'b0);
    check_stream("t1", 5, 11);
    check_eq("t1_busy", busy_at1, 1);
    check_eq("t1_done_at", done_at, last_valid + 4);
    check_eq("t1_timeout", to_at_done, 0);

    // 2: single word
    mem[0] = 16'hA5C3;
    run_load(1, 0, 2, 1'b0);
    check_eq("t2_word", pack16(), 16'hA5C3);
    check_eq("t2_len", n_valid, 16);
    check_eq("t2_first", first_valid, 3);
    check_eq("t2_nre", n_re, 1);
    check_eq("t2_addr", (got_addrs.size() > 0) ? got_addrs[0] : -1, 0);

    // 3: zero datapoints
    run_load(0, 7, 1, 1'b0);
    check_eq("t3_nre", n_re, 0);
    check_eq("t3_nvalid", n_valid, 0);
    check_eq("t3_done_at", done_at, 1);
    check_eq("t3_busy", busy_at1, 0);
    check_eq("t3_ndone", done_cnt, 1);

    // 4: start re-pulsed and num_dp changed mid-stream; sink_done high on entry cycle
    run_load(2, 3, 1, 1'b1);
    check_stream("t4", 2, 3);
    check_eq("t4_done_at", done_at, last_valid + 2);

    // 5: sink_done never arrives
    run_load(1, 1, -1, 1'b0);
    check_eq("t5_len", n_valid, 32);
    check_eq("t5_timeout", to_at_done, 1);
    check_eq("t5_done_at", done_at, last_valid + TO + 1);
    run_load(1, 0, 1, 1'b0);
    check_eq("t5_clear_at_start", to_at1, 0);
    check_eq("t5_clear_done", to_at_done, 0);

    // 6: asynchronous reset at bit 5 of word 2
    @(negedge CLK);
    num_dp = 3'd5;
    feat   = 5'd11;
    start  = 1'b1;
    seen   = 0;
    pre_v  = 1'b0;
    for (int cyc = 0; cyc < 200 && seen < 38; cyc++) begin
      @(negedge CLK);
      start = 1'b0;
      if (ser_valid) seen++;
    end
    check_eq("t6_reached", seen, 38);
    pre_v = ser_valid;
    #2 RST = 1'b0;
    #1;
    check_eq("t6_pre_valid", pre_v, 1);
    check_eq("t6_async_drop", {28'd0, ser, ser_valid, mem_re, busy}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    run_load(1, 0, 1, 1'b0);
    check_eq("t6_word", pack16(), 16'hA5C3);
    check_eq("t6_len", n_valid, 16);
    check_eq("t6_first", first_valid, 3);
    check_eq("t6_ndone", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
